// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
// Optional build macro: TX_SCHED_GAP_EN adds the inter-byte GAP state.
package uart_tx_sched_pkg;

    // Scheduler state encoding
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3
`ifdef TX_SCHED_GAP_EN
        ,
        ST_GAP       = 3'd4
`endif
    } sched_state_e;

    // Requester indices into the arbiter request/grant vectors
    localparam int REQ_ALU = 0;
    localparam int REQ_REG = 1;

    // Bytes carried per frame by each requester
    localparam logic [1:0] ALU_BYTES = 2'd2;
    localparam logic [1:0] REG_BYTES = 2'd1;

endpackage

// File: rtl/uart_tx_scheduler_arb.sv
// rr_arbiter2: two-way round-robin arbiter. The requester that did not win
// the last accepted grant has priority on a tie; last_grant only moves when
// the winner's transfer is actually accepted.
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant;

    // Grant the lone requester, or on a tie the one not served last
    always_comb begin
        grant[0] = req[0] & (~req[1] | last_grant);
        grant[1] = req[1] & (~req[0] | ~last_grant);
    end

    // Remember who was served; reset favours requester 0 on the first tie
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between the ALU (two-byte
// results, low byte first) and the register file (single byte). Arbitrates
// round-robin, issues each byte as a one-cycle strobe, waits for the UART
// busy flag to rise then fall, and aborts a frame whose busy never rises.
// Optional build macro: TX_SCHED_GAP_EN inserts GAP_CYCLES idle cycles after
// every byte.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 15,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ0_Valid,
    input  logic [2*DATA_WIDTH-1:0] REQ0_Data,
    output logic                    REQ0_Ready,
    input  logic                    REQ1_Valid,
    input  logic [DATA_WIDTH-1:0]   REQ1_Data,
    output logic                    REQ1_Ready,
    input  logic                    TX_Busy,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_Data_Valid,
    output logic                    Sched_Active,
    output logic                    Timeout_Err
);

    // One counter serves both the busy-rise timeout and the optional gap
    localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
`ifdef TX_SCHED_GAP_EN
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
`endif

    sched_state_e              state_q, state_d;
    logic [2*DATA_WIDTH-1:0]   data_q, data_d;
    logic [1:0]                bytes_q, bytes_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      terr_q, terr_d;
    logic [1:0]                grant;
    logic                      arb_update;

    rr_arbiter2 u_arb (
        .CLK    (CLK),
        .RST    (RST),
        .req    ({REQ1_Valid, REQ0_Valid}),
        .update (arb_update),
        .grant  (grant)
    );

    // The UART samples the low byte of the shift register for the whole frame
    assign TX_P_DATA   = data_q[DATA_WIDTH-1:0];
    assign Timeout_Err = terr_q;

    // Next-state, datapath and output decode for the scheduler FSM
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bytes_d    = bytes_q;
        cnt_d      = cnt_q;
        terr_d     = 1'b0;

        REQ0_Ready    = grant[REQ_ALU] & (state_q == ST_IDLE) & ~TX_Busy;
        REQ1_Ready    = grant[REQ_REG] & (state_q == ST_IDLE) & ~TX_Busy;
        arb_update    = (REQ0_Valid & REQ0_Ready) | (REQ1_Valid & REQ1_Ready);
        TX_Data_Valid = (state_q == ST_ISSUE);
        Sched_Active  = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (REQ0_Valid & REQ0_Ready) begin
                    data_d  = REQ0_Data;
                    bytes_d = ALU_BYTES;
                    state_d = ST_ISSUE;
                end else if (REQ1_Valid & REQ1_Ready) begin
                    data_d  = {{DATA_WIDTH{1'b0}}, REQ1_Data};
                    bytes_d = REG_BYTES;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (TX_Busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // UART never acknowledged: abandon the rest of the frame
                    terr_d  = 1'b1;
                    bytes_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_WAIT_DONE: begin
                // No timeout here: frame length depends on baud and parity
                if (!TX_Busy) begin
                    if (bytes_q > 2'd1) begin
                        data_d  = data_q >> DATA_WIDTH;
                        bytes_d = bytes_q - 2'd1;
                    end else begin
                        bytes_d = '0;
                    end
`ifdef TX_SCHED_GAP_EN
                    cnt_d   = '0;
                    state_d = ST_GAP;
`else
                    state_d = (bytes_q > 2'd1) ? ST_ISSUE : ST_IDLE;
`endif
                end
            end

`ifdef TX_SCHED_GAP_EN
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = (bytes_q != 2'd0) ? ST_ISSUE : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    // NOTE: the capture register is reset too, because TX_P_DATA is driven
    // straight from it and must read zero while in reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            bytes_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            bytes_q <= bytes_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler. A simple UART model raises busy
// one cycle after each strobe and drops it twelve cycles later; a scoreboard
// queue holds the bytes each scenario expects on TX_P_DATA, in order.
// Honours TX_SCHED_GAP_EN for the inter-byte spacing expectation.
module tb_uart_tx_scheduler;

    localparam int DW = 8;
    localparam int BT = 15;
    localparam int GC = 4;
`ifdef TX_SCHED_GAP_EN
    localparam int GAP_DELAY = 1 + GC;
`else
    localparam int GAP_DELAY = 1;
`endif

    logic          CLK;
    logic          RST;
    logic          REQ0_Valid;
    logic [2*DW-1:0] REQ0_Data;
    logic          REQ0_Ready;
    logic          REQ1_Valid;
    logic [DW-1:0] REQ1_Data;
    logic          REQ1_Ready;
    logic          TX_Busy;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_Data_Valid;
    logic          Sched_Active;
    logic          Timeout_Err;

    logic model_busy;
    logic force_busy;
    bit   uart_en;

    int   checks;
    int   errors;
    int   cyc;
    int   strobe_cnt;
    logic [7:0] last_strobe_data;
    logic [7:0] exp_q[$];
    int   strobe_cyc_q[$];
    int   fall_cyc_q[$];

    assign TX_Busy = model_busy | force_busy;

    uart_tx_scheduler #(
        .DATA_WIDTH   (DW),
        .BUSY_TIMEOUT (BT),
        .GAP_CYCLES   (GC)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .REQ0_Valid    (REQ0_Valid),
        .REQ0_Data     (REQ0_Data),
        .REQ0_Ready    (REQ0_Ready),
        .REQ1_Valid    (REQ1_Valid),
        .REQ1_Data     (REQ1_Data),
        .REQ1_Ready    (REQ1_Ready),
        .TX_Busy       (TX_Busy),
        .TX_P_DATA     (TX_P_DATA),
        .TX_Data_Valid (TX_Data_Valid),
        .Sched_Active  (Sched_Active),
        .Timeout_Err   (Timeout_Err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // UART model: busy rises 1 cycle after a strobe, falls 12 cycles later
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (uart_en && TX_Data_Valid === 1'b1) begin
                @(posedge CLK);
                #1 model_busy = 1'b1;
                repeat (12) @(posedge CLK);
                #1 model_busy = 1'b0;
                fall_cyc_q.push_back(cyc);
            end
        end
    end

    // Scoreboard: every strobe must match the next expected byte
    initial begin : monitor
        logic       prev_dv;
        logic [7:0] e;
        prev_dv    = 1'b0;
        strobe_cnt = 0;
        forever begin
            @(negedge CLK);
            if (TX_Data_Valid === 1'b1) begin
                strobe_cnt++;
                strobe_cyc_q.push_back(cyc);
                last_strobe_data = TX_P_DATA;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: TX_P_DATA=0x%02h at cycle %0d, no byte was due", TX_P_DATA, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (TX_P_DATA !== e) begin
                        errors++;
                        $display("FAIL strobe_data: got 0x%02h, expected 0x%02h", TX_P_DATA, e);
                    end
                end
                checks++;
                if (prev_dv) begin
                    errors++;
                    $display("FAIL strobe_width: TX_Data_Valid high on consecutive cycles, expected 1-cycle pulse");
                end
            end
            prev_dv = (TX_Data_Valid === 1'b1);
        end
    end

    task automatic await_ready(input int idx, input string name);
        int   n;
        logic r;
        n = 0;
        #1;
        r = (idx == 0) ? REQ0_Ready : REQ1_Ready;
        while (r !== 1'b1 && n < 300) begin
            @(negedge CLK);
            #1;
            n++;
            r = (idx == 0) ? REQ0_Ready : REQ1_Ready;
        end
        checks++;
        if (r !== 1'b1) begin
            errors++;
            $display("FAIL %s: REQ%0d_Ready=%b after %0d cycles, expected 1", name, idx, r, n);
        end
    endtask

    // Let the accepting edge pass, then withdraw the request; h = strobe cycle
    task automatic accept_and_drop(input int idx, output int h);
        @(posedge CLK);
        @(negedge CLK);
        h = cyc;
        if (idx == 0) REQ0_Valid = 1'b0;
        else          REQ1_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge CLK);
        while ((Sched_Active !== 1'b0 || TX_Busy !== 1'b0 || exp_q.size() != 0) && n < 400) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (Sched_Active !== 1'b0 || TX_Busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: Sched_Active=%b pending=%0d after %0d cycles, expected idle with 0 pending",
                     name, Sched_Active, exp_q.size(), n);
        end
    endtask

    task automatic test_reset;
        RST        = 1'b0;
        REQ0_Valid = 1'b0;
        REQ0_Data  = '0;
        REQ1_Valid = 1'b0;
        REQ1_Data  = '0;
        force_busy = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({TX_P_DATA, TX_Data_Valid, REQ0_Ready, REQ1_Ready, Sched_Active, Timeout_Err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: data=0x%02h dv=%b r0=%b r1=%b act=%b terr=%b, expected all 0",
                     TX_P_DATA, TX_Data_Valid, REQ0_Ready, REQ1_Ready, Sched_Active, Timeout_Err);
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (Sched_Active !== 1'b0 || TX_Data_Valid !== 1'b0 || TX_P_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: act=%b dv=%b data=0x%02h, expected 0/0/0x00",
                     Sched_Active, TX_Data_Valid, TX_P_DATA);
        end
    endtask

    task automatic test_round_robin;
        int h;
        // Both valid straight after reset: ALU first, then register file
        @(negedge CLK);
        REQ0_Data = 16'h1234; REQ0_Valid = 1'b1;
        REQ1_Data = 8'hA5;    REQ1_Valid = 1'b1;
        exp_q.push_back(8'h34); exp_q.push_back(8'h12); exp_q.push_back(8'hA5);
        #1;
        checks++;
        if (REQ0_Ready !== 1'b1 || REQ1_Ready !== 1'b0) begin
            errors++;
            $display("FAIL tie_after_reset: r0=%b r1=%b, expected r0=1 r1=0", REQ0_Ready, REQ1_Ready);
        end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (REQ0_Ready !== 1'b0 || REQ1_Ready !== 1'b0 || Sched_Active !== 1'b1) begin
            errors++;
            $display("FAIL ready_while_active: r0=%b r1=%b act=%b, expected 0/0/1",
                     REQ0_Ready, REQ1_Ready, Sched_Active);
        end
        // REQ0 stays valid: the register file must still win next
        await_ready(1, "rr_req1_after_req0");
        checks++;
        if (REQ0_Ready !== 1'b0) begin
            errors++;
            $display("FAIL rr_held_both: r0=%b with REQ1 granted, expected 0", REQ0_Ready);
        end
        @(posedge CLK);
        @(negedge CLK);
        REQ0_Valid = 1'b0;
        REQ1_Valid = 1'b0;
        wait_idle("rr_phase1_idle");

        // ALU served last, so a fresh tie goes to the register file
        @(negedge CLK);
        REQ0_Data = 16'hBEEF; REQ0_Valid = 1'b1;
        exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        await_ready(0, "rr_req0_alone");
        accept_and_drop(0, h);
        wait_idle("rr_phase2_idle");
        @(negedge CLK);
        REQ0_Data = 16'h5566; REQ0_Valid = 1'b1;
        REQ1_Data = 8'h3C;    REQ1_Valid = 1'b1;
        exp_q.push_back(8'h3C); exp_q.push_back(8'h66); exp_q.push_back(8'h55);
        #1;
        checks++;
        if (REQ1_Ready !== 1'b1 || REQ0_Ready !== 1'b0) begin
            errors++;
            $display("FAIL tie_after_alu: r0=%b r1=%b, expected r0=0 r1=1", REQ0_Ready, REQ1_Ready);
        end
        accept_and_drop(1, h);
        await_ready(0, "rr_req0_second");
        accept_and_drop(0, h);
        wait_idle("rr_phase3_idle");
    endtask

    task automatic test_req1_only;
        int base;
        int h;
        base = strobe_cnt;
        strobe_cyc_q.delete();
        @(negedge CLK);
        REQ1_Data = 8'hA5; REQ1_Valid = 1'b1;
        exp_q.push_back(8'hA5);
        await_ready(1, "req1_only_ready");
        accept_and_drop(1, h);
        wait_idle("req1_only_idle");
        checks++;
        if (strobe_cnt - base != 1) begin
            errors++;
            $display("FAIL req1_strobe_count: got %0d strobes, expected 1", strobe_cnt - base);
        end
        checks++;
        if (strobe_cyc_q.size() == 0 || strobe_cyc_q[0] != h) begin
            errors++;
            $display("FAIL req1_latency: strobe cycle %0d, expected %0d",
                     (strobe_cyc_q.size() == 0) ? -1 : strobe_cyc_q[0], h);
        end
    endtask

    task automatic test_req0_only;
        int base;
        int h;
        int n;
        bit hold_ok;
        base = strobe_cnt;
        strobe_cyc_q.delete();
        fall_cyc_q.delete();
        @(negedge CLK);
        REQ0_Data = 16'h1234; REQ0_Valid = 1'b1;
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        await_ready(0, "req0_only_ready");
        accept_and_drop(0, h);
        n       = 0;
        hold_ok = 1'b1;
        while (Sched_Active === 1'b1 && n < 400) begin
            if (TX_Data_Valid !== 1'b1 && TX_Busy === 1'b1 && TX_P_DATA !== last_strobe_data)
                hold_ok = 1'b0;
            @(negedge CLK);
            n++;
        end
        checks++;
        if (strobe_cnt - base != 2) begin
            errors++;
            $display("FAIL req0_active_span: %0d strobes before Sched_Active fell, expected 2", strobe_cnt - base);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL req0_data_hold: TX_P_DATA changed while busy, expected held");
        end
        wait_idle("req0_only_idle");
        checks++;
        if (strobe_cyc_q.size() < 2 || fall_cyc_q.size() < 1 || strobe_cyc_q[1] != fall_cyc_q[0] + GAP_DELAY) begin
            errors++;
            $display("FAIL req0_byte_spacing: second strobe cycle %0d, expected busy-low cycle + %0d",
                     (strobe_cyc_q.size() < 2) ? -1 : strobe_cyc_q[1], GAP_DELAY);
        end
        checks++;
        if (strobe_cyc_q.size() == 0 || strobe_cyc_q[0] != h) begin
            errors++;
            $display("FAIL req0_latency: first strobe cycle %0d, expected %0d",
                     (strobe_cyc_q.size() == 0) ? -1 : strobe_cyc_q[0], h);
        end
    endtask

    task automatic test_busy_idle;
        int h;
        bit ok;
        ok = 1'b1;
        force_busy = 1'b1;
        @(negedge CLK);
        REQ1_Data = 8'h77; REQ1_Valid = 1'b1;
        repeat (6) begin
            #1;
            if (REQ1_Ready !== 1'b0 || Sched_Active !== 1'b0) ok = 1'b0;
            @(negedge CLK);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_blocks_grant: REQ1_Ready or Sched_Active rose while TX_Busy=1, expected 0");
        end
        force_busy = 1'b0;
        #1;
        checks++;
        if (REQ1_Ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_release_grant: REQ1_Ready=%b after busy fell, expected 1", REQ1_Ready);
        end
        exp_q.push_back(8'h77);
        accept_and_drop(1, h);
        wait_idle("busy_idle_done");
    endtask

    task automatic test_timeout;
        int base;
        int h;
        int n;
        uart_en = 1'b0;
        base    = strobe_cnt;
        @(negedge CLK);
        REQ0_Data = 16'hCAFE; REQ0_Valid = 1'b1;
        exp_q.push_back(8'hFE);
        await_ready(0, "timeout_ready");
        accept_and_drop(0, h);
        n = 0;
        while (Timeout_Err !== 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (Timeout_Err !== 1'b1 || cyc - h != 1 + BT) begin
            errors++;
            $display("FAIL timeout_time: Timeout_Err=%b at %0d cycles after strobe, expected 1 at %0d",
                     Timeout_Err, cyc - h, 1 + BT);
        end
        checks++;
        if (Sched_Active !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: Sched_Active=%b at pulse, expected 0", Sched_Active);
        end
        @(negedge CLK);
        checks++;
        if (Timeout_Err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_width: Timeout_Err=%b one cycle later, expected 0", Timeout_Err);
        end
        repeat (20) @(negedge CLK);
        checks++;
        if (strobe_cnt - base != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_drop: %0d strobes, %0d pending, expected 1 strobe 0 pending",
                     strobe_cnt - base, exp_q.size());
        end
        uart_en = 1'b1;
    endtask

    task automatic test_reset_mid_frame;
        int base;
        int h;
        int n;
        base = strobe_cnt;
        @(negedge CLK);
        REQ0_Data = 16'h1234; REQ0_Valid = 1'b1;
        exp_q.push_back(8'h34);
        await_ready(0, "midreset_ready");
        accept_and_drop(0, h);
        n = 0;
        while (TX_Busy !== 1'b1 && n < 30) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (Sched_Active !== 1'b1 || TX_Busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: act=%b busy=%b, expected both 1", Sched_Active, TX_Busy);
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({TX_P_DATA, TX_Data_Valid, REQ0_Ready, REQ1_Ready, Sched_Active, Timeout_Err} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_outputs: data=0x%02h dv=%b r0=%b r1=%b act=%b terr=%b, expected all 0",
                     TX_P_DATA, TX_Data_Valid, REQ0_Ready, REQ1_Ready, Sched_Active, Timeout_Err);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        REQ1_Data = 8'h5A; REQ1_Valid = 1'b1;
        exp_q.push_back(8'h5A);
        await_ready(1, "midreset_req1_ready");
        accept_and_drop(1, h);
        wait_idle("midreset_idle");
        checks++;
        if (strobe_cnt - base != 2) begin
            errors++;
            $display("FAIL midreset_strobes: %0d strobes, expected 2 (0x34 then 0x5A)", strobe_cnt - base);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        uart_en    = 1'b1;
        force_busy = 1'b0;
        RST        = 1'b0;
        REQ0_Valid = 1'b0;
        REQ1_Valid = 1'b0;
        REQ0_Data  = '0;
        REQ1_Data  = '0;

        test_reset;
        test_round_robin;
        test_req1_only;
        test_req0_only;
        test_busy_idle;
        test_timeout;
        test_reset_mid_frame;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes never sent, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
